// File: rtl/fifo_burst_reader_if.sv
// Handshake bundle for fifo_burst_reader: show-ahead FIFO read side plus the
// valid/ready burst output side.
interface fifo_burst_reader_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] fifo_q;
  logic                  fifo_rdempty;
  logic                  fifo_rdreq;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_last;
  logic                  out_ready;

  modport master (
    input  fifo_q, fifo_rdempty, out_ready,
    output fifo_rdreq, out_data, out_valid, out_last
  );

  modport slave (
    output fifo_q, fifo_rdempty, out_ready,
    input  fifo_rdreq, out_data, out_valid, out_last
  );
endinterface

// File: rtl/fifo_burst_reader.sv
// Drains a show-ahead FIFO into bursts of up to BURST_LEN words through a hold
// and an output register. Optional burst/timeout counters: define BURST_STATS_EN.
module fifo_burst_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 16,
  parameter int TIMEOUT    = 255
) (
  input  logic                         rdclk,
  input  logic                         clear_n,
  input  logic                         enable,
  output logic [$clog2(BURST_LEN)-1:0] beat_idx,
`ifdef BURST_STATS_EN
  output logic [15:0]                  burst_cnt,
  output logic [15:0]                  tmo_cnt,
`endif
  fifo_burst_reader_if.master          bus
);

  localparam int IDX_W = $clog2(BURST_LEN);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BURST_LEN - 1);
  localparam logic [CNT_W-1:0] TMO_VAL  = CNT_W'(TIMEOUT);

  typedef enum logic {
    EMPTY = 1'b0,
    HELD  = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_last_q, out_last_d;
  logic [IDX_W-1:0]      beat_q, beat_d;
  logic [CNT_W-1:0]      idle_q, idle_d;

  logic hold_valid;
  logic out_free;
  logic pop;
  logic tmo_hit;
  logic at_last;
  logic move;
  logic move_last;

  assign hold_valid = (state_q == HELD);
  assign out_free   = !out_valid_q | bus.out_ready;
  assign pop        = enable & !bus.fifo_rdempty & (!hold_valid | out_free);
  assign tmo_hit    = (idle_q == TMO_VAL);
  assign at_last    = (beat_q == LAST_IDX);
  // A held word leaves only once we know whether it closes the burst.
  assign move       = hold_valid & out_free & (pop | at_last | tmo_hit | !enable);
  assign move_last  = at_last | ((tmo_hit | !enable) & !pop);

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path leaves it unassigned (no latch).
    state_d     = state_q;
    hold_d      = hold_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    beat_d      = beat_q;
    idle_d      = idle_q;

    unique case (state_q)
      EMPTY: if (pop) state_d = HELD;
      HELD:  if (move && !pop) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase

    if (pop) hold_d = bus.fifo_q;

    if (move) begin
      out_valid_d = 1'b1;
      out_data_d  = hold_q;
      out_last_d  = move_last;
      beat_d      = move_last ? '0 : beat_q + IDX_W'(1);
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    if (pop || !hold_valid) begin
      idle_d = '0;
    end else if (!tmo_hit) begin
      idle_d = idle_q + CNT_W'(1);
    end
  end

  // NOTE: the data registers are reset too, since out_data must read zero during reset.
  always_ff @(posedge rdclk or negedge clear_n) begin
    if (!clear_n) begin
      state_q     <= EMPTY;
      hold_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      beat_q      <= '0;
      idle_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q     <= state_d;
      hold_q      <= hold_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      beat_q      <= beat_d;
      idle_q      <= idle_d;
    end
  end

  assign bus.fifo_rdreq = pop;
  assign bus.out_data   = out_data_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_last   = out_last_q;
  assign beat_idx       = beat_q;

`ifdef BURST_STATS_EN
  logic [15:0] burst_cnt_q, tmo_cnt_q;

  // A burst counts as timed out when the idle limit, not a full burst or enable drop, closes it.
  always_ff @(posedge rdclk or negedge clear_n) begin
    if (!clear_n) begin
      burst_cnt_q <= '0;
      tmo_cnt_q   <= '0;
    end else begin
      if (out_valid_q && bus.out_ready && out_last_q) burst_cnt_q <= burst_cnt_q + 16'd1;
      if (move && move_last && tmo_hit && !pop && !at_last && enable) tmo_cnt_q <= tmo_cnt_q + 16'd1;
    end
  end

  assign burst_cnt = burst_cnt_q;
  assign tmo_cnt   = tmo_cnt_q;
`endif

endmodule
